// File: rtl/yurut_birim_siralayici_if.sv
// Issue sequencer bus: decode request, unit start/ready/result lines,
// downstream hold and the held result.
interface yurut_birim_siralayici_if;
  logic        durdur_i;
  logic        istek_gecerli_i;
  logic [1:0]  istek_birim_i;
  logic [4:0]  istek_hedef_i;
  logic        istek_yaz_i;
  logic        istek_kabul_o;
  logic        yurut_stall_o;
  logic [2:0]  birim_basla_o;
  logic [2:0]  birim_hazir_i;
  logic [31:0] amb_sonuc_i;
  logic [31:0] yz_sonuc_i;
  logic [31:0] kripto_sonuc_i;
  logic        sonuc_gecerli_o;
  logic [31:0] sonuc_o;
  logic [4:0]  hedef_yazmaci_o;
  logic        yazmaca_yaz_o;
  logic        hata_o;

  // Environment side: decode, functional units and the downstream stage.
  modport master (
    output durdur_i, istek_gecerli_i, istek_birim_i, istek_hedef_i, istek_yaz_i,
    output birim_hazir_i, amb_sonuc_i, yz_sonuc_i, kripto_sonuc_i,
    input  istek_kabul_o, yurut_stall_o, birim_basla_o,
    input  sonuc_gecerli_o, sonuc_o, hedef_yazmaci_o, yazmaca_yaz_o, hata_o
  );

  // Sequencer side.
  modport slave (
    input  durdur_i, istek_gecerli_i, istek_birim_i, istek_hedef_i, istek_yaz_i,
    input  birim_hazir_i, amb_sonuc_i, yz_sonuc_i, kripto_sonuc_i,
    output istek_kabul_o, yurut_stall_o, birim_basla_o,
    output sonuc_gecerli_o, sonuc_o, hedef_yazmaci_o, yazmaca_yaz_o, hata_o
  );
endinterface

// File: rtl/yurut_birim_siralayici.sv
// Execute-stage issue sequencer for the multi-cycle units (AMB, YZ, KRIPTO).
// One operation in flight: start pulse, wait for the unit's ready (or
// timeout), hold the tagged result until the downstream stage releases it.
module yurut_birim_siralayici #(
  parameter int unsigned ZAMAN_ASIMI = 64  // legal range 2..255
) (
  input logic                     clk_i,
  input logic                     rst_i,
  yurut_birim_siralayici_if.slave yb
);

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    BEKLE = 2'd1,
    SONUC = 2'd2
  } durum_t;

  localparam logic [7:0] SAYAC_SON = 8'(ZAMAN_ASIMI - 1);

  durum_t      durum;
  logic [1:0]  secim;
  logic [4:0]  hedef;
  logic        yaz;
  logic [7:0]  sayac;

  logic [2:0]  basla_r;
  logic        gecerli_r;
  logic [31:0] sonuc_r;
  logic [4:0]  hedef_r;
  logic        yaz_r;
  logic        hata_r;

  logic        kabul;
  logic        secili_hazir;
  logic [31:0] secili_sonuc;
  logic        zaman_doldu;

  // Request acceptance: idle, or releasing a held result in the same cycle.
  always_comb begin
    kabul = yb.istek_gecerli_i &&
            ((durum == BOSTA) || ((durum == SONUC) && !yb.durdur_i));
  end

  // Ready and result of the selected unit only; other units' ready bits are ignored.
  always_comb begin
    secili_hazir = 1'b0;
    secili_sonuc = '0;
    case (secim)
      2'd0: begin
        secili_hazir = yb.birim_hazir_i[0];
        secili_sonuc = yb.amb_sonuc_i;
      end
      2'd1: begin
        secili_hazir = yb.birim_hazir_i[1];
        secili_sonuc = yb.yz_sonuc_i;
      end
      2'd2: begin
        secili_hazir = yb.birim_hazir_i[2];
        secili_sonuc = yb.kripto_sonuc_i;
      end
      default: begin
        secili_hazir = 1'b0;
        secili_sonuc = '0;
      end
    endcase
  end

  // Timeout boundary: last unfrozen wait cycle.
  always_comb begin
    zaman_doldu = (sayac == SAYAC_SON);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum     <= BOSTA;
      secim     <= '0;
      hedef     <= '0;
      yaz       <= 1'b0;
      sayac     <= '0;
      basla_r   <= '0;
      gecerli_r <= 1'b0;
      sonuc_r   <= '0;
      hedef_r   <= '0;
      yaz_r     <= 1'b0;
      hata_r    <= 1'b0;
    end else begin
      basla_r <= '0;
      hata_r  <= 1'b0;
      case (durum)
        BOSTA, SONUC: begin
          if (kabul) begin
            secim <= yb.istek_birim_i;
            hedef <= yb.istek_hedef_i;
            sayac <= '0;
            if (yb.istek_birim_i == 2'd3) begin
              // Illegal unit: no start, straight to an error result.
              yaz       <= 1'b0;
              durum     <= SONUC;
              gecerli_r <= 1'b1;
              sonuc_r   <= '0;
              hedef_r   <= yb.istek_hedef_i;
              yaz_r     <= 1'b0;
              hata_r    <= 1'b1;
            end else begin
              yaz       <= yb.istek_yaz_i;
              durum     <= BEKLE;
              basla_r   <= 3'b001 << yb.istek_birim_i;
              gecerli_r <= 1'b0;
              sonuc_r   <= '0;
              hedef_r   <= '0;
              yaz_r     <= 1'b0;
            end
          end else if ((durum == SONUC) && !yb.durdur_i) begin
            durum     <= BOSTA;
            gecerli_r <= 1'b0;
            sonuc_r   <= '0;
            hedef_r   <= '0;
            yaz_r     <= 1'b0;
          end
        end
        BEKLE: begin
          // Ready wins over the timeout boundary and over durdur_i.
          if (secili_hazir) begin
            durum     <= SONUC;
            gecerli_r <= 1'b1;
            sonuc_r   <= secili_sonuc;
            hedef_r   <= hedef;
            yaz_r     <= yaz;
          end else if (!yb.durdur_i) begin
            if (zaman_doldu) begin
              durum     <= SONUC;
              gecerli_r <= 1'b1;
              sonuc_r   <= '0;
              hedef_r   <= hedef;
              yaz_r     <= 1'b0;
              hata_r    <= 1'b1;
            end else begin
              sayac <= sayac + 8'd1;
            end
          end
        end
        default: begin
          durum <= BOSTA;
        end
      endcase
    end
  end

  assign yb.istek_kabul_o   = kabul;
  assign yb.yurut_stall_o   = yb.istek_gecerli_i && !kabul;
  assign yb.birim_basla_o   = basla_r;
  assign yb.sonuc_gecerli_o = gecerli_r;
  assign yb.sonuc_o         = sonuc_r;
  assign yb.hedef_yazmaci_o = hedef_r;
  assign yb.yazmaca_yaz_o   = yaz_r;
  assign yb.hata_o          = hata_r;

endmodule

// File: tb/tb_yurut_birim_siralayici.sv
// Scoreboard bench for yurut_birim_siralayici: the driver emulates decode,
// the units and the downstream hold, and queues the expected start pulse and
// result (with its cycle) per operation; a negedge monitor checks them.
module tb_yurut_birim_siralayici;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  yurut_birim_siralayici_if yb();

  yurut_birim_siralayici #(.ZAMAN_ASIMI(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .yb    (yb)
  );

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] sonuc;
    logic [4:0]  hedef;
    logic        yaz;
  } sonuc_bek_t;

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } basla_bek_t;

  sonuc_bek_t sq[$];
  basla_bek_t bq[$];

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;
  logic busy   = 1'b0;
  logic held   = 1'b0;
  logic [31:0] h_sonuc;
  logic [4:0]  h_hedef;
  logic        h_yaz;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string ad, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", ad, cyc, got, exp);
    end
  endtask

  // Monitor: start pulses, results, acceptance and stall against the model.
  always @(negedge clk) begin : mon
    sonuc_bek_t e;
    logic       kabul_bek;
    if (mon_en) begin
      if (bq.size() > 0 && bq[0].cyc == cyc) begin
        chk("basla", 32'(yb.birim_basla_o), 32'(bq[0].val));
        void'(bq.pop_front());
      end else begin
        chk("basla_yok", 32'(yb.birim_basla_o), 32'd0);
      end

      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        e = sq.pop_front();
        chk("sonuc_gecerli", 32'(yb.sonuc_gecerli_o), 32'd1);
        chk("sonuc", yb.sonuc_o, e.sonuc);
        chk("hedef", 32'(yb.hedef_yazmaci_o), 32'(e.hedef));
        chk("yaz", 32'(yb.yazmaca_yaz_o), 32'(e.yaz));
        chk("hata", 32'(yb.hata_o), 32'(e.err));
        held    = 1'b1;
        busy    = 1'b0;
        h_sonuc = e.sonuc;
        h_hedef = e.hedef;
        h_yaz   = e.yaz;
      end else if (held) begin
        chk("tut_gecerli", 32'(yb.sonuc_gecerli_o), 32'd1);
        chk("tut_sonuc", yb.sonuc_o, h_sonuc);
        chk("tut_hedef", 32'(yb.hedef_yazmaci_o), 32'(h_hedef));
        chk("tut_yaz", 32'(yb.yazmaca_yaz_o), 32'(h_yaz));
        chk("tut_hata", 32'(yb.hata_o), 32'd0);
      end else begin
        chk("gecerli_yok", 32'(yb.sonuc_gecerli_o), 32'd0);
        chk("hata_yok", 32'(yb.hata_o), 32'd0);
      end

      kabul_bek = yb.istek_gecerli_i && !busy && !(held && yb.durdur_i);
      chk("kabul", 32'(yb.istek_kabul_o), 32'(kabul_bek));
      chk("stall", 32'(yb.yurut_stall_o), 32'(yb.istek_gecerli_i && !kabul_bek));
      if (kabul_bek) busy = 1'b1;
      if (held && !yb.durdur_i) held = 1'b0;
    end
  end

  // One operation. d: ready delay after the start cycle (-1 = never answers);
  // hfrz: durdur_i cycles at the start of a timeout wait; ilk_dur: durdur_i
  // cycles while presenting (-1 = random); bek_dur: random durdur_i while
  // waiting for ready; stray: force other-unit ready pulses; pre: keep a
  // next request pending while waiting.
  task automatic do_op(input logic [1:0] u, input logic [4:0] h, input logic y,
                       input logic [31:0] data, input int d, input int hfrz,
                       input int ilk_dur, input bit bek_dur, input bit stray,
                       input bit pre);
    int         n;
    int         son;
    sonuc_bek_t e;
    basla_bek_t b;
    logic       err;
    yb.istek_gecerli_i = 1'b1;
    yb.istek_birim_i   = u;
    yb.istek_hedef_i   = h;
    yb.istek_yaz_i     = y;
    n = 0;
    forever begin
      yb.durdur_i = (ilk_dur >= 0) ? (n < ilk_dur) : ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (yb.istek_kabul_o) break;
      n++;
      if (n > 3 * TO + 10) begin
        n_cmp++;
        n_bad++;
        $display("FAIL kabul_bekleme cyc=%0d got=no_accept exp=accept", cyc);
        $fatal(1, "request never accepted");
      end
      @(posedge clk);
      #1;
    end
    err     = (u == 2'd3) || (d < 0);
    e.cyc   = (u == 2'd3) ? cyc + 1 : (d >= 0) ? cyc + 2 + d : cyc + 1 + hfrz + TO;
    e.err   = err;
    e.sonuc = err ? 32'd0 : data;
    e.hedef = h;
    e.yaz   = err ? 1'b0 : y;
    sq.push_back(e);
    if (u != 2'd3) begin
      b.cyc = cyc + 1;
      b.val = 3'b001 << u;
      bq.push_back(b);
    end
    @(posedge clk);
    #1;
    yb.istek_gecerli_i = 1'b0;
    if (u == 2'd3) return;
    son = (d >= 0) ? d : hfrz + TO - 1;
    for (int k = 0; k <= son; k++) begin
      if (pre || $urandom_range(0, 3) == 0) begin
        yb.istek_gecerli_i = 1'b1;
        yb.istek_birim_i   = 2'($urandom);
        yb.istek_hedef_i   = 5'($urandom);
        yb.istek_yaz_i     = 1'($urandom);
      end else begin
        yb.istek_gecerli_i = 1'b0;
      end
      if (d >= 0) yb.durdur_i = bek_dur && ($urandom_range(0, 3) == 0);
      else        yb.durdur_i = (k < hfrz);
      yb.amb_sonuc_i    = $urandom;
      yb.yz_sonuc_i     = $urandom;
      yb.kripto_sonuc_i = $urandom;
      yb.birim_hazir_i  = '0;
      if (stray || $urandom_range(0, 3) == 0)
        yb.birim_hazir_i = 3'($urandom) & ~(3'b001 << u);
      if (k == d) begin
        yb.birim_hazir_i[u] = 1'b1;
        case (u)
          2'd0:    yb.amb_sonuc_i    = data;
          2'd1:    yb.yz_sonuc_i     = data;
          default: yb.kripto_sonuc_i = data;
        endcase
      end
      @(posedge clk);
      #1;
    end
    yb.birim_hazir_i   = '0;
    yb.istek_gecerli_i = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    n_bad++;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    logic [1:0] u;
    int         d;
    int         hf;
    int         t;
    yb.durdur_i = 1'b0;
    yb.istek_gecerli_i = 1'b0;
    yb.istek_birim_i = '0;
    yb.istek_hedef_i = '0;
    yb.istek_yaz_i = 1'b0;
    yb.birim_hazir_i = '0;
    yb.amb_sonuc_i = '0;
    yb.yz_sonuc_i = '0;
    yb.kripto_sonuc_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_basla", 32'(yb.birim_basla_o), 32'd0);
    chk("rst_gecerli", 32'(yb.sonuc_gecerli_o), 32'd0);
    chk("rst_sonuc", yb.sonuc_o, 32'd0);
    chk("rst_hedef", 32'(yb.hedef_yazmaci_o), 32'd0);
    chk("rst_yaz", 32'(yb.yazmaca_yaz_o), 32'd0);
    chk("rst_hata", 32'(yb.hata_o), 32'd0);
    chk("rst_stall", 32'(yb.yurut_stall_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed operations.
    do_op(2'd0, 5'd5, 1'b1, 32'h0000_00A5, 2, 0, 0, 1'b0, 1'b0, 1'b0);
    do_op(2'd2, 5'd7, 1'b1, 32'h1234_5678, 4, 0, -1, 1'b1, 1'b1, 1'b0);
    do_op(2'd1, 5'd12, 1'b1, 32'hCAFE_0001, -1, 0, 0, 1'b0, 1'b0, 1'b1);
    do_op(2'd0, 5'd3, 1'b1, 32'h0000_0033, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    do_op(2'd1, 5'd20, 1'b1, 32'h0BAD_F00D, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    do_op(2'd0, 5'd21, 1'b0, 32'h0000_0021, 0, 0, 3, 1'b0, 1'b0, 1'b0);
    do_op(2'd3, 5'd9, 1'b1, 32'h0, 0, 0, -1, 1'b0, 1'b0, 1'b0);
    do_op(2'd0, 5'd1, 1'b1, 32'h5555_AAAA, TO - 1, 0, 0, 1'b0, 1'b0, 1'b1);
    do_op(2'd2, 5'd4, 1'b1, 32'h0, -1, 5, -1, 1'b0, 1'b0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 200; i++) begin
      u  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      hf = 0;
      if ($urandom_range(0, 11) == 0) begin
        d  = -1;
        hf = $urandom_range(0, 4);
      end else if ($urandom_range(0, 9) == 0) begin
        d = $urandom_range(6, TO - 1);
      end else begin
        d = $urandom_range(0, 5);
      end
      do_op(u, 5'($urandom), 1'($urandom), $urandom, d, hf, -1, 1'b1, 1'($urandom), 1'($urandom));
    end

    yb.durdur_i = 1'b0;
    yb.istek_gecerli_i = 1'b0;
    t = 0;
    while ((sq.size() > 0 || bq.size() > 0) && t < 3 * TO) begin
      @(posedge clk);
      t++;
    end
    n_cmp++;
    if (sq.size() > 0 || bq.size() > 0) begin
      n_bad++;
      $display("FAIL kuyruk_bos cyc=%0d got=%0d/%0d exp=0/0", cyc, sq.size(), bq.size());
    end
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;

    // Reset during the second wait cycle, then a late ready pulse.
    yb.istek_gecerli_i = 1'b1;
    yb.istek_birim_i = 2'd0;
    yb.istek_hedef_i = 5'd3;
    yb.istek_yaz_i = 1'b1;
    @(negedge clk);
    chk("rb_kabul", 32'(yb.istek_kabul_o), 32'd1);
    @(posedge clk);
    #1;
    yb.istek_gecerli_i = 1'b0;
    @(negedge clk);
    chk("rb_basla", 32'(yb.birim_basla_o), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    yb.birim_hazir_i = 3'b001;
    yb.amb_sonuc_i = 32'h0000_0055;
    @(negedge clk);
    chk("rb_basla0", 32'(yb.birim_basla_o), 32'd0);
    chk("rb_gecerli0", 32'(yb.sonuc_gecerli_o), 32'd0);
    chk("rb_sonuc0", yb.sonuc_o, 32'd0);
    chk("rb_hedef0", 32'(yb.hedef_yazmaci_o), 32'd0);
    chk("rb_yaz0", 32'(yb.yazmaca_yaz_o), 32'd0);
    chk("rb_hata0", 32'(yb.hata_o), 32'd0);
    @(posedge clk);
    #1;
    yb.birim_hazir_i = '0;
    yb.istek_gecerli_i = 1'b1;
    yb.istek_birim_i = 2'd3;
    yb.istek_hedef_i = 5'd9;
    yb.durdur_i = 1'b1;
    @(negedge clk);
    chk("rb_gecerli1", 32'(yb.sonuc_gecerli_o), 32'd0);
    chk("rb_bosta_kabul", 32'(yb.istek_kabul_o), 32'd1);
    @(posedge clk);
    #1;
    yb.istek_gecerli_i = 1'b0;
    @(negedge clk);
    chk("rb_yasak_hata", 32'(yb.hata_o), 32'd1);
    chk("rb_yasak_gecerli", 32'(yb.sonuc_gecerli_o), 32'd1);
    chk("rb_yasak_yaz", 32'(yb.yazmaca_yaz_o), 32'd0);
    chk("rb_yasak_basla", 32'(yb.birim_basla_o), 32'd0);
    @(posedge clk);
    #1;
    yb.durdur_i = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/yurut_birim_siralayici.md
# yurut_birim_siralayici

Issue sequencer for the execute stage's multi-cycle functional units (AMB, yapay zeka hızlandırıcı, kriptografi birimi). It accepts one operation at a time from decode and sends a one-cycle start pulse to the selected unit. It then waits for that unit's ready pulse, latches the unit's result with its destination-register tag, and holds that result until the downstream stage releases it. It produces the execute-stage stall and flags units that never answer.

## Interface
- ZAMAN_ASIMI, default 64: maximum BEKLE cycles (unfrozen) before timeout; legal range 2..255.
- clk_i  input  1  single clock; all state updates on posedge.
- rst_i  input  1  reset: synchronous, active-high.
- durdur_i  input  1  downstream hold; freezes SONUC and the BEKLE counter.
- istek_gecerli_i  input  1  decode presents an operation.
- istek_birim_i  input  2  target unit: 0 AMB, 1 YZ, 2 KRIPTO, 3 illegal.
- istek_hedef_i  input  5  destination register.
- istek_yaz_i  input  1  operation writes the register file.
- istek_kabul_o  output  1  operation accepted this cycle (combinational).
- yurut_stall_o  output  1  istek_gecerli_i && !istek_kabul_o (combinational).
- birim_basla_o  output  3  one-hot start pulse: bit0 AMB, bit1 YZ, bit2 KRIPTO.
- birim_hazir_i  input  3  per-unit ready pulse, same bit order.
- amb_sonuc_i, yz_sonuc_i, kripto_sonuc_i  input  32 each  unit results, valid while the matching birim_hazir_i bit is high.
- sonuc_gecerli_o  output  1  held result valid.
- sonuc_o  output  32  held result.
- hedef_yazmaci_o  output  5  held destination register.
- yazmaca_yaz_o  output  1  held write enable; forced 0 on error.
- hata_o  output  1  one-cycle pulse on timeout or illegal unit.

## Operation
- States: BOSTA (idle), BEKLE (waiting), SONUC (result held). Registers: secim (2 b), hedef, yaz, sayac (8 b), sonuc.
- istek_kabul_o = istek_gecerli_i && (BOSTA || (SONUC && !durdur_i)).
- On acceptance: latch istek_birim_i, istek_hedef_i and istek_yaz_i; clear sayac.
  - Legal unit: go to BEKLE.
  - Unit 3: go to SONUC with sonuc=0 and yaz=0, pulse hata_o, issue no start.
- SONUC without acceptance: if !durdur_i go to BOSTA; otherwise stay with all outputs stable.
- BEKLE:
  - birim_basla_o = one-hot(secim) only in the first BEKLE cycle (registered, sayac==0).
  - birim_hazir_i[secim] high: capture that unit's result and go to SONUC.
  - Ready bits of non-selected units are ignored at all times.
  - No ready and !durdur_i: sayac increments.
  - No ready and durdur_i: sayac holds.
  - sayac==ZAMAN_ASIMI-1 with no ready and !durdur_i: go to SONUC with sonuc=0 and yaz=0, pulse hata_o.
  - Ready in the same cycle as the timeout boundary: ready wins, no error.
- Only one operation is ever in flight. New requests stall through BEKLE and through SONUC while durdur_i is high.
- Reset (any state, including mid-BEKLE):
  - State returns to BOSTA; sayac and all registers clear.
  - All outputs go to 0; a ready pulse arriving after reset is ignored.

## Timing
- Cycle N: acceptance.
- Cycle N+1: BEKLE, birim_basla_o high for exactly one cycle.
- Ready is accepted from N+1 onward. A ready at cycle R gives sonuc_gecerli_o high from R+1.
- Minimum accept-to-result latency is 2 cycles (same-cycle ready at N+1).
- Back-to-back: a result in SONUC with !durdur_i and a new request lets the next operation be accepted in that same cycle. Throughput is one operation per 2 cycles for single-cycle units.
- Timeout: with durdur_i low, hata_o pulses in SONUC entry cycle N+1+ZAMAN_ASIMI.
- Illegal unit: hata_o and sonuc_gecerli_o at N+1.
- All outputs are registered except istek_kabul_o and yurut_stall_o.

## Test plan
- Reset, then AMB request (hedef=5, yaz=1); amb ready at N+3 with 0x0000_00A5:
  - birim_basla_o=3'b001 only at N+1.
  - sonuc_gecerli_o=1, sonuc_o=0xA5, hedef_yazmaci_o=5, yazmaca_yaz_o=1 at N+4.
  - Back to BOSTA the next cycle.
- KRIPTO request; YZ and AMB pulse ready with 0xDEAD_BEEF before the kripto ready; kripto ready with 0x1234_5678:
  - Stray ready pulses are ignored; sonuc_o=0x1234_5678.
- YZ request with no ready, ZAMAN_ASIMI=64:
  - hata_o pulses once at N+65, sonuc_o=0, yazmaca_yaz_o=0.
  - yurut_stall_o is high for every BEKLE cycle while a new request waits.
- Result held with durdur_i high for 3 cycles and a second request pending:
  - Outputs stay stable and yurut_stall_o=1.
  - On the durdur_i fall the second request is accepted in that cycle.
- istek_birim_i=3, hedef=9:
  - No birim_basla_o bit ever set.
  - hata_o=1, sonuc_gecerli_o=1, yazmaca_yaz_o=0 at N+1.
- rst_i asserted in the 2nd BEKLE cycle, amb ready the cycle after:
  - All outputs are 0 and the state is BOSTA.
  - The ready is ignored and sonuc_gecerli_o stays 0.
